// File: rtl/prog_pkg.sv
// prog_pkg -- shared definitions for the program-fetch sequencer.
//   fetch_state_t : IDLE / RUN / DRAIN encoding (also used by the debug state port)
//   P_SIZE_DEF    : default program address width
//   I_SIZE_DEF    : default instruction width
//   RET_DEPTH     : return-stack depth (used only when PROG_FETCH_RET_STACK_EN is defined)
//   NOP           : value held in the IR after reset
package prog_pkg;

  localparam int P_SIZE_DEF = 6;
  localparam int I_SIZE_DEF = 24;
  localparam int RET_DEPTH  = 4;

  localparam logic [I_SIZE_DEF-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/prog_fetch_ctrl_if.sv
// prog_fetch_ctrl_if -- instruction hand-off between the fetch sequencer and decode.
//   fetch modport  : drives ir / ir_valid / ir_pc, receives ir_ready and redirect controls
//   decode modport : the mirror image
//   PROG_FETCH_RET_STACK_EN adds call / ret redirect controls.
//
// Handshake: an instruction transfers on a rising edge where ir_valid && ir_ready.
// While ir_valid is high and ir_ready is low, ir and ir_pc stay stable. ir_valid
// never depends combinationally on ir_ready. br_take / br_rel / br_target (and
// call / ret) are only looked at on a transfer edge and belong to the instruction
// being transferred.
interface prog_fetch_ctrl_if
  import prog_pkg::*;
#(
  parameter int P_SIZE = P_SIZE_DEF,
  parameter int I_SIZE = I_SIZE_DEF
);

  logic [I_SIZE-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic [P_SIZE-1:0] ir_pc;
  logic              br_take;
  logic              br_rel;
  logic [P_SIZE-1:0] br_target;
`ifdef PROG_FETCH_RET_STACK_EN
  logic              call;
  logic              ret;
`endif

  modport fetch (
    output ir, ir_valid, ir_pc,
    input  ir_ready, br_take, br_rel, br_target
`ifdef PROG_FETCH_RET_STACK_EN
    , input call, ret
`endif
  );

  modport decode (
    input  ir, ir_valid, ir_pc,
    output ir_ready, br_take, br_rel, br_target
`ifdef PROG_FETCH_RET_STACK_EN
    , output call, ret
`endif
  );

endinterface

// File: rtl/prog_ret_stack.sv
// prog_ret_stack -- small circular LIFO of return addresses.
//   clk, rst   : clock, asynchronous active-high reset (clears the stack)
//   push       : store push_data on top; when full the oldest entry is overwritten
//   pop        : remove the top entry (ignored when empty)
//   push_data  : address to store
//   pop_data   : current top entry, or EMPTY_VAL when the stack is empty
// pop has priority over push if both are asserted. DEPTH must be a power of two.
module prog_ret_stack
  import prog_pkg::*;
#(
  parameter int              W         = P_SIZE_DEF,
  parameter int              DEPTH     = RET_DEPTH,
  parameter logic [W-1:0]    EMPTY_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] sp_q, sp_d;     // next write slot
  logic [PW:0]   cnt_q, cnt_d;   // live entries, saturates at DEPTH
  logic [PW-1:0] top_idx;

  // Writing at sp when full lands on the oldest entry, which gives the
  // overwrite-oldest behaviour without any extra bookkeeping.
  assign top_idx  = sp_q - 1'b1;
  assign pop_data = (cnt_q == '0) ? EMPTY_VAL : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (pop) begin
      if (cnt_q != '0) begin
        sp_d  = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (push) begin
      mem_d[sp_q] = push_data;
      sp_d        = sp_q + 1'b1;
      if (cnt_q != (PW+1)'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_fetch_ctrl.sv
// prog_fetch_ctrl -- instruction-fetch sequencer.
// Owns the PC, addresses a combinational program memory, captures the word into
// the IR and hands it to decode. Supports absolute/relative branch redirect,
// run/halt control and PC wrap-around.
//   clk, reset   : clock, asynchronous active-high reset
//   run, halt    : start/resume fetching (level); stop, drain IR, go idle (halt wins)
//   pc_addr      : program memory address (the PC register)
//   prog_instr   : program memory word at pc_addr
//   busy         : state != IDLE
//   dbg_state    : current fetch_state_t encoding
//   dec          : decode hand-off (prog_fetch_ctrl_if.fetch)
// Optional: PROG_FETCH_RET_STACK_EN adds call/ret via a RET_DEPTH return stack.
module prog_fetch_ctrl
  import prog_pkg::*;
#(
  parameter int                P_SIZE     = P_SIZE_DEF,
  parameter int                I_SIZE     = I_SIZE_DEF,
  parameter logic [P_SIZE-1:0] RESET_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                halt,
  output logic [P_SIZE-1:0]   pc_addr,
  input  logic [I_SIZE-1:0]   prog_instr,
  output logic                busy,
  output logic [1:0]          dbg_state,
  prog_fetch_ctrl_if.fetch    dec
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        state_q, state_d;
  logic [P_SIZE-1:0] pc_q, pc_d;
  logic [P_SIZE-1:0] ir_pc_q, ir_pc_d;
  logic [I_SIZE-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;

  logic              consume;
  logic              redirect;
  logic              load;
  logic [P_SIZE-1:0] target;

  assign consume = ir_valid_q && dec.ir_ready;

`ifdef PROG_FETCH_RET_STACK_EN
  logic              do_call;
  logic              do_ret;
  logic [P_SIZE-1:0] ret_addr;
  logic [P_SIZE-1:0] link_addr;

  // ret > call > br_take
  assign do_ret    = consume && dec.ret;
  assign do_call   = consume && dec.call && !dec.ret;
  assign redirect  = consume && (dec.ret || dec.call || dec.br_take);
  assign link_addr = ir_pc_q + P_SIZE'(1);

  prog_ret_stack #(
    .W         (P_SIZE),
    .DEPTH     (RET_DEPTH),
    .EMPTY_VAL (RESET_ADDR)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (reset),
    .push      (do_call),
    .pop       (do_ret),
    .push_data (link_addr),
    .pop_data  (ret_addr)
  );

  always_comb begin
    target = dec.br_target;
    if (dec.ret)         target = ret_addr;
    else if (dec.call)   target = dec.br_target;
    else if (dec.br_rel) target = ir_pc_q + dec.br_target;
  end
`else
  assign redirect = consume && dec.br_take;
  // P_SIZE-bit add wraps, giving the modulo-2**P_SIZE relative target.
  assign target   = dec.br_rel ? (ir_pc_q + dec.br_target) : dec.br_target;
`endif

  // A redirect kills the fetch that would otherwise happen alongside it, so the
  // word at the old pc never enters the IR (the one-cycle bubble). halt in RUN
  // also suppresses the load so draining starts from a stable IR.
  assign load = (state_q == S_RUN) && !halt && (!ir_valid_q || dec.ir_ready) && !redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (consume) ir_valid_d = 1'b0;
    if (load) begin
      ir_d       = prog_instr;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + P_SIZE'(1);
    end
    if (redirect) pc_d = target;

    case (state_q)
      S_IDLE:  if (run && !halt) state_d = S_RUN;
      S_RUN:   if (halt)         state_d = S_DRAIN;
      // No loads in DRAIN, so ir_valid_d low means the IR is empty or emptying now.
      S_DRAIN: if (!ir_valid_d)  state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_ADDR;
      ir_q       <= I_SIZE'(NOP);
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign pc_addr      = pc_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;
  assign dec.ir       = ir_q;
  assign dec.ir_valid = ir_valid_q;
  assign dec.ir_pc    = ir_pc_q;

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// tb_prog_fetch_ctrl -- bench for prog_fetch_ctrl. Program memory word at address a
// is {8'hC3, 10'h0, a}. Expected ir_pc values are queued by the stimulus and popped
// on every transfer. With PROG_FETCH_RET_STACK_EN defined, call/ret are exercised too.
module tb_prog_fetch_ctrl;
  import prog_pkg::*;

  localparam int PS = 6;
  localparam int IS = 24;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          run   = 1'b0;
  logic          halt  = 1'b0;
  logic [PS-1:0] pc_addr;
  logic [IS-1:0] prog_instr;
  logic          busy;
  logic [1:0]    dbg_state;

  prog_fetch_ctrl_if #(.P_SIZE(PS), .I_SIZE(IS)) bus ();

  prog_fetch_ctrl #(
    .P_SIZE     (PS),
    .I_SIZE     (IS),
    .RESET_ADDR ('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .halt       (halt),
    .pc_addr    (pc_addr),
    .prog_instr (prog_instr),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dec        (bus)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  function automatic logic [IS-1:0] instr_of(input logic [PS-1:0] a);
    return {8'hC3, 10'h000, a};
  endfunction

  assign prog_instr = instr_of(pc_addr);

  // ---------------- scoreboard ----------------
  logic [PS-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  // Called at a falling edge: a transfer is about to happen on the next rising edge.
  task automatic mon();
    logic [PS-1:0] e;
    check("idle_no_valid", {31'b0, (dbg_state == 2'(IDLE)) && bus.ir_valid}, 32'd0);
    if (bus.ir_valid && bus.ir_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 32'(bus.ir_pc), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("ir_pc", 32'(bus.ir_pc), 32'(e));
        check("ir", 32'(bus.ir), 32'(instr_of(e)));
      end
    end
  endtask

  // Advance, consuming as the bench's ir_ready allows, until ir_valid with ir_pc==v
  // is seen at a falling edge (left there, not yet checked).
  task automatic wait_for_pc(input logic [PS-1:0] v);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      to_neg();
      if (bus.ir_valid && bus.ir_pc == v) begin
        found = 1'b1;
        break;
      end
      mon();
      to_pos();
    end
    if (!found) check("timeout_wait_pc", 32'(bus.ir_pc), 32'(v));
  endtask

  // kind 0: br_take, 1: call, 2: ret -- attached to the transfer of ir_pc==v
  task automatic redirect_at(input logic [PS-1:0] v, input int kind, input logic rel,
                             input logic [PS-1:0] tgt);
    wait_for_pc(v);
    bus.br_rel    = rel;
    bus.br_target = tgt;
    if (kind == 0) bus.br_take = 1'b1;
`ifdef PROG_FETCH_RET_STACK_EN
    if (kind == 1) bus.call = 1'b1;
    if (kind == 2) bus.ret  = 1'b1;
`endif
    mon();
    to_pos();
    bus.br_take = 1'b0;
    bus.br_rel  = 1'b0;
`ifdef PROG_FETCH_RET_STACK_EN
    bus.call = 1'b0;
    bus.ret  = 1'b0;
`endif
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(PS'(i));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.ir_ready  = 1'b0;
    bus.br_take   = 1'b0;
    bus.br_rel    = 1'b0;
    bus.br_target = '0;
`ifdef PROG_FETCH_RET_STACK_EN
    bus.call = 1'b0;
    bus.ret  = 1'b0;
`endif

    // reset state
    #8;
    check("rst_pc_addr", 32'(pc_addr), 32'd0);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ir", 32'(bus.ir), 32'd0);
    check("rst_ir_pc", 32'(bus.ir_pc), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    #4 reset = 1'b0;
    to_pos();

    // start: RUN next edge, first IR one edge later
    run = 1'b1;
    bus.ir_ready = 1'b1;
    to_pos();
    check("run_busy", 32'(busy), 32'd1);
    check("run_no_load_yet", 32'(bus.ir_valid), 32'd0);
    check("run_pc_addr", 32'(pc_addr), 32'd0);
    to_pos();
    check("first_valid", 32'(bus.ir_valid), 32'd1);
    check("first_pc_addr", 32'(pc_addr), 32'd1);

    // sequential fetch, 3-cycle stall at ir_pc=5
    push_range(0, 10);
    wait_for_pc(6'd5);
    bus.ir_ready = 1'b0;
    repeat (3) begin
      to_pos();
      check("stall_ir_pc", 32'(bus.ir_pc), 32'd5);
      check("stall_ir", 32'(bus.ir), 32'(instr_of(6'd5)));
      check("stall_pc_addr", 32'(pc_addr), 32'd6);
      check("stall_valid", 32'(bus.ir_valid), 32'd1);
    end
    to_neg();
    bus.ir_ready = 1'b1;
    mon();
    to_pos();

    // relative branch -4 from 10 -> 6, one bubble
    redirect_at(6'd10, 0, 1'b1, 6'h3C);
    check("bubble_valid", 32'(bus.ir_valid), 32'd0);
    check("bubble_pc_addr", 32'(pc_addr), 32'd6);

    // absolute branch to 60, wrap 63 -> 0
    push_range(6, 8);
    redirect_at(6'd8, 0, 1'b0, 6'd60);
    push_range(60, 63);
    push_range(0, 2);
    // absolute branch to 63 from ir_pc=2, then wrap
    redirect_at(6'd2, 0, 1'b0, 6'd63);
    exp_q.push_back(6'd63);
    push_range(0, 1);

    // halt during stall at ir_pc=1
    wait_for_pc(6'd1);
    bus.ir_ready = 1'b0;
    halt = 1'b1;
    repeat (2) begin
      to_pos();
      check("drain_state", 32'(dbg_state), 32'(DRAIN));
      check("drain_valid", 32'(bus.ir_valid), 32'd1);
      check("drain_ir_pc", 32'(bus.ir_pc), 32'd1);
      check("drain_pc_addr", 32'(pc_addr), 32'd2);
    end
    to_neg();
    bus.ir_ready = 1'b1;
    mon();
    to_pos();
    check("halt_idle_state", 32'(dbg_state), 32'(IDLE));
    check("halt_idle_busy", 32'(busy), 32'd0);
    check("halt_idle_valid", 32'(bus.ir_valid), 32'd0);
    check("halt_idle_pc", 32'(pc_addr), 32'd2);
    to_pos();
    check("halt_wins_over_run", 32'(dbg_state), 32'(IDLE));
    halt = 1'b0;
    push_range(2, 4);
    wait_for_pc(6'd3);
    mon();
    to_pos();

    // halt together with an absolute branch to 20
    wait_for_pc(6'd4);
    halt = 1'b1;
    bus.br_take   = 1'b1;
    bus.br_rel    = 1'b0;
    bus.br_target = 6'd20;
    mon();
    to_pos();
    bus.br_take = 1'b0;
    check("hb_state", 32'(dbg_state), 32'(DRAIN));
    check("hb_valid", 32'(bus.ir_valid), 32'd0);
    check("hb_pc_addr", 32'(pc_addr), 32'd20);
    to_pos();
    check("hb_idle", 32'(dbg_state), 32'(IDLE));
    check("hb_pc_hold", 32'(pc_addr), 32'd20);
    halt = 1'b0;
    push_range(20, 21);
    wait_for_pc(6'd21);
    mon();
    to_pos();

    // asynchronous reset between edges while running
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.ir_valid), 32'd0);
    check("arst_pc_addr", 32'(pc_addr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    to_pos();
    reset = 1'b0;
    check("q_empty_base", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

`ifdef PROG_FETCH_RET_STACK_EN
    // call at 3 to 20, ret at 20 -> 4
    push_range(0, 3);
    redirect_at(6'd3, 1, 1'b0, 6'd20);
    exp_q.push_back(6'd20);
    redirect_at(6'd20, 2, 1'b0, 6'd0);
    // five calls (oldest link 5 overwritten), five rets, last one hits empty
    exp_q.push_back(6'd4);
    redirect_at(6'd4, 1, 1'b0, 6'd10);
    exp_q.push_back(6'd10);
    redirect_at(6'd10, 1, 1'b0, 6'd20);
    exp_q.push_back(6'd20);
    redirect_at(6'd20, 1, 1'b0, 6'd30);
    exp_q.push_back(6'd30);
    redirect_at(6'd30, 1, 1'b0, 6'd40);
    exp_q.push_back(6'd40);
    redirect_at(6'd40, 1, 1'b0, 6'd50);
    exp_q.push_back(6'd50);
    redirect_at(6'd50, 2, 1'b0, 6'd0);
    exp_q.push_back(6'd41);
    redirect_at(6'd41, 2, 1'b0, 6'd0);
    exp_q.push_back(6'd31);
    redirect_at(6'd31, 2, 1'b0, 6'd0);
    exp_q.push_back(6'd21);
    redirect_at(6'd21, 2, 1'b0, 6'd0);
    exp_q.push_back(6'd11);
    redirect_at(6'd11, 2, 1'b0, 6'd0);
    exp_q.push_back(6'd0);
    wait_for_pc(6'd0);
    mon();
    to_pos();
    check("q_empty_stack", 32'(exp_q.size()), 32'd0);
`endif

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
